// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multicycle MIPS core. Sequences the shared ALU,
//   the single memory port, the IR, the register file and the PC mux over
//   several cycles per instruction, waits on mem_ready for every memory
//   access and flags unsupported opcodes.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   opcode[5:0]  IR[31:26], stable from end of FETCH until the next FETCH
//   zero         ALU zero flag (same cycle)
//   mem_ready    memory completes the current access this cycle
//   pc_en        PC load enable
//   i_or_d       memory address select (0 = PC, 1 = ALUOut)
//   mem_read     memory read request (level)
//   mem_write    memory write request (level)
//   ir_write     IR load enable
//   mem_to_reg   register write data select (1 = MDR, 0 = ALUOut)
//   reg_dst      destination select (1 = rd, 0 = rt)
//   reg_write    register file write enable
//   alu_src_a    ALU A select (0 = PC, 1 = A)
//   alu_src_b    ALU B select (00 B, 01 +4, 10 imm, 11 imm<<2)
//   alu_op       ALU op (00 add, 01 sub, 10 funct)
//   pc_source    PC source (00 ALU, 01 ALUOut, 10 jump target)
//   illegal_op   one-cycle pulse in DECODE on an unsupported opcode
//   state[3:0]   current state, debug only
//
// State table
//   state   | meaning
//   FETCH   | read instruction at PC, PC+4 into PC once memory answers
//   DECODE  | register read, branch target (PC + imm<<2) into ALUOut
//   MEMADR  | effective address A + imm for lw/sw
//   MEMRD   | data read at ALUOut, held until mem_ready
//   MEMWB   | MDR -> rt
//   MEMWR   | data write at ALUOut, held until mem_ready
//   EXEC    | R-type ALU operation
//   RWB     | ALUOut -> rd
//   BRANCH  | compare A/B, conditional PC <- ALUOut
//   JUMP    | PC <- jump target
//   ADDI_EX | A + imm
//   ADDI_WB | ALUOut -> rt
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11
  } state_t;

  state_t r_state;

  logic w_is_lw;
  logic w_is_sw;
  logic w_is_beq;
  logic w_is_bne;
  logic w_legal;

  assign w_is_lw  = (opcode == OP_LW);
  assign w_is_sw  = (opcode == OP_SW);
  assign w_is_beq = (opcode == OP_BEQ);
  assign w_is_bne = (opcode == OP_BNE);
  assign w_legal  = w_is_lw || w_is_sw || w_is_beq || w_is_bne ||
                    (opcode == OP_RTYPE) || (opcode == OP_J) ||
                    (opcode == OP_ADDI);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   r_state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW:   r_state <= S_MEMADR;
            OP_RTYPE:       r_state <= S_EXEC;
            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
            OP_J:           r_state <= S_JUMP;
            OP_ADDI:        r_state <= S_ADDI_EX;
            default:        r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          if (w_is_lw)      r_state <= S_MEMRD;
          else if (w_is_sw) r_state <= S_MEMWR;
          else              r_state <= S_FETCH;
        end
        S_MEMRD:   r_state <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   r_state <= mem_ready ? S_FETCH : S_MEMWR;
        S_EXEC:    r_state <= S_RWB;
        S_RWB:     r_state <= S_FETCH;
        S_BRANCH:  r_state <= S_FETCH;
        S_JUMP:    r_state <= S_FETCH;
        S_ADDI_EX: r_state <= S_ADDI_WB;
        S_ADDI_WB: r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode of the registered state. pc_en and ir_write look at the
  // same-cycle handshake/flag inputs so the PC and IR load on the edge that
  // ends the state; reset masks every enable so an aborted instruction
  // leaves no architectural side effect.
  always_comb begin
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b11;
        illegal_op = ~w_legal;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_en     = (w_is_beq && zero) || (w_is_bne && !zero);
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_en     = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: begin
      end
    endcase
    if (reset) begin
      pc_en      = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      illegal_op = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic       mr;
    logic       z;
    logic [5:0] opc;
    exp_t       e;
  } cyc_t;

  exp_t sb[$];
  cyc_t seq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_push = 0;
  int   n_pop = 0;

  // Datapath control word the ISA needs in each step, enables aside
  // from those that depend on run-time inputs (filled in by the builder).
  function automatic exp_t step(input int st);
    exp_t e;
    e = '0;
    e.st = 4'(st);
    case (st)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; end
      1:  e.alu_src_b = 2'b11;
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.mem_read = 1; e.i_or_d = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      5:  begin e.mem_write = 1; e.i_or_d = 1; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_write = 1; e.reg_dst = 1; end
      8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01; end
      9:  e.pc_source = 2'b10;
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      11: e.reg_write = 1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic void add(input logic [5:0] opc, input logic mr,
                              input logic z, input exp_t e);
    cyc_t c;
    c.rst = 1'b0; c.mr = mr; c.z = z; c.opc = opc; c.e = e;
    seq.push_back(c);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Whole-instruction expectation: fetch (with wf wait cycles), decode, then
  // the opcode's own steps (wm wait cycles on the data access).
  task automatic build(input logic [5:0] opc, input int wf, input int wm,
                       input logic z);
    exp_t e;
    for (int i = 0; i < wf; i++) add(opc, 1'b0, rb(), step(0));
    e = step(0); e.ir_write = 1; e.pc_en = 1;
    add(opc, 1'b1, rb(), e);
    e = step(1);
    case (opc)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
      6'b000010, 6'b001000: e.illegal_op = 0;
      default: e.illegal_op = 1;
    endcase
    add(opc, rb(), rb(), e);
    case (opc)
      6'b100011: begin
        add(opc, rb(), rb(), step(2));
        for (int i = 0; i < wm; i++) add(opc, 1'b0, rb(), step(3));
        add(opc, 1'b1, rb(), step(3));
        add(opc, rb(), rb(), step(4));
      end
      6'b101011: begin
        add(opc, rb(), rb(), step(2));
        for (int i = 0; i < wm; i++) add(opc, 1'b0, rb(), step(5));
        add(opc, 1'b1, rb(), step(5));
      end
      6'b000000: begin
        add(opc, rb(), rb(), step(6));
        add(opc, rb(), rb(), step(7));
      end
      6'b001000: begin
        add(opc, rb(), rb(), step(10));
        add(opc, rb(), rb(), step(11));
      end
      6'b000100, 6'b000101: begin
        e = step(8);
        e.pc_en = (opc == 6'b000100) ? z : ~z;
        add(opc, rb(), z, e);
      end
      6'b000010: begin
        e = step(9); e.pc_en = 1;
        add(opc, rb(), rb(), e);
      end
      default: ;
    endcase
  endtask

  function automatic exp_t quiet(input exp_t e);
    exp_t q;
    q = e;
    q.pc_en = 0; q.mem_read = 0; q.mem_write = 0;
    q.ir_write = 0; q.reg_write = 0; q.illegal_op = 0;
    return q;
  endfunction

  // Reset lands in cycle k of the instruction: that cycle shows the current
  // state with enables masked, the next cycle (reset still high) is FETCH.
  task automatic inject_reset(input int k);
    cyc_t c;
    c = seq[k];
    while (seq.size() > k) void'(seq.pop_back());
    c.rst = 1; c.e = quiet(c.e);
    seq.push_back(c);
    c.e = quiet(step(0));
    seq.push_back(c);
  endtask

  task automatic run();
    foreach (seq[i]) begin
      @(posedge clk);
      #1;
      reset     = seq[i].rst;
      mem_ready = seq[i].mr;
      zero      = seq[i].z;
      opcode    = seq[i].opc;
      sb.push_back(seq[i].e);
      n_push++;
    end
    seq.delete();
  endtask

  task automatic instr(input logic [5:0] opc, input int wf, input int wm,
                       input logic z, input int rst_at);
    build(opc, wf, wm, z);
    if (rst_at >= 0 && rst_at < seq.size()) inject_reset(rst_at);
    run();
  endtask

  always @(negedge clk) begin
    exp_t a, x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      n_pop++;
      a = {state, pc_en, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           illegal_op};
      n_cmp++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL cycle%0d ctl: got st=%0d word=%b, expected st=%0d word=%b",
                 n_pop, a.st, a[15:0], x.st, x[15:0]);
      end
    end
  end

  function automatic logic [5:0] rand_illegal();
    logic [5:0] o;
    do o = 6'($urandom_range(0, 63));
    while (o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                     6'b000101, 6'b000010, 6'b001000});
    return o;
  endfunction

  initial begin
    logic [5:0] ops [8];
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000;
    ops[3] = 6'b000100; ops[4] = 6'b000101; ops[5] = 6'b000010;
    ops[6] = 6'b001000; ops[7] = 6'b111111;

    reset = 1; mem_ready = 0; zero = 0; opcode = 6'b000000;
    @(posedge clk);
    #1;
    // Second reset cycle: state must already be FETCH with enables masked.
    begin
      cyc_t c;
      c.rst = 1; c.mr = 1; c.z = 0; c.opc = 6'b000000; c.e = quiet(step(0));
      seq.push_back(c);
      run();
    end

    instr(6'b100011, 0, 0, 0, -1);   // lw
    instr(6'b101011, 0, 2, 0, -1);   // sw, two wait cycles
    instr(6'b000100, 0, 0, 1, -1);   // beq taken
    instr(6'b000101, 0, 0, 1, -1);   // bne not taken
    instr(6'b000010, 0, 0, 0, -1);   // j
    instr(6'b111111, 0, 0, 0, -1);   // illegal
    instr(6'b100011, 3, 0, 0, -1);   // fetch waits
    instr(6'b100011, 0, 1, 0, 3);    // reset during MEMRD wait
    instr(6'b001000, 0, 0, 0, -1);   // addi
    instr(6'b000000, 0, 0, 0, -1);   // R-type

    for (int n = 0; n < 200; n++) begin
      int sel;
      logic [5:0] o;
      int wf, wm, ra;
      sel = $urandom_range(0, 7);
      o = (sel == 7) ? rand_illegal() : ops[sel];
      wf = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      wm = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3) : 0;
      ra = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : -1;
      instr(o, wf, wm, rb(), ra);
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #2;
    n_cmp++;
    if (n_pop != n_push) begin
      n_bad++;
      $display("FAIL drain: compared %0d cycles, expected %0d", n_pop, n_push);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
